// File: rtl/fb_pkg.sv
// Shared geometry, palette defaults and types for the Game Boy framebuffer arbiter.
package fb_pkg;

    localparam int unsigned WIDTH  = 160;
    localparam int unsigned HEIGHT = 144;
    localparam int unsigned ADDR_W = 15;

    localparam logic [23:0] PAL0 = 24'hE0F8D0;
    localparam logic [23:0] PAL1 = 24'h88C070;
    localparam logic [23:0] PAL2 = 24'h346856;
    localparam logic [23:0] PAL3 = 24'h081820;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_RD,
        GNT_WR
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        shade;
    } wr_entry_t;

    // y*160 + x built from shifts; caller guarantees the coordinate is in range
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [11:0] x, input logic [11:0] y);
        logic [19:0] sum;
        sum = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {8'd0, x};
        return sum[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO buffering PPU pixel writes until the RAM port is free.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clock25mhz,
    input  logic      resetn,
    input  logic      push,
    input  wr_entry_t push_data,
    input  logic      pop,
    output wr_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock25mhz or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock25mhz) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win, PPU writes drain from a FIFO
// in idle cycles, and read shades are mapped through the palette to RGB.
module fb_scan_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [23:0] PAL0       = fb_pkg::PAL0,
    parameter logic [23:0] PAL1       = fb_pkg::PAL1,
    parameter logic [23:0] PAL2       = fb_pkg::PAL2,
    parameter logic [23:0] PAL3       = fb_pkg::PAL3
) (
    input  logic                      clock25mhz,
    input  logic                      resetn,
    input  logic [11:0]               scan_x,
    input  logic [11:0]               scan_y,
    input  logic                      lcd_on,
    output logic [7:0]                rgb_r,
    output logic [7:0]                rgb_g,
    output logic [7:0]                rgb_b,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [7:0]                wr_x,
    input  logic [7:0]                wr_y,
    input  logic [1:0]                wr_shade,
    output logic [fb_pkg::ADDR_W-1:0] ram_addr,
    output logic                      ram_we,
    output logic [1:0]                ram_wdata,
    input  logic [1:0]                ram_rdata,
    output logic                      wr_drop,
    output logic                      scan_overrun
);

    import fb_pkg::*;

    logic [23:0] prev_xy_q;
    logic        scan_in_range;
    logic        scan_req;
    grant_e      grant;

    logic        wr_in_range;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    wr_entry_t   fifo_in;
    wr_entry_t   fifo_head;

    logic        rd_pend_q;
    logic        lcd_pend_q;
    logic        pix_valid_q;
    logic        lcd_q;
    logic [1:0]  shade_q;
    logic [23:0] rgb;
    logic        wr_drop_q;
    logic        scan_overrun_q;

    // A read is requested only when the timing generator moves to a new visible pixel
    assign scan_in_range = (32'(scan_x) < WIDTH) && (32'(scan_y) < HEIGHT);
    assign scan_req      = resetn && scan_in_range && ({scan_x, scan_y} != prev_xy_q);

    assign wr_ready    = resetn && !fifo_full;
    assign wr_in_range = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
    assign fifo_push   = wr_valid && wr_ready && wr_in_range;
    assign fifo_in     = '{addr: pix_addr(12'(wr_x), 12'(wr_y)), shade: wr_shade};

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clock25mhz (clock25mhz),
        .resetn     (resetn),
        .push       (fifo_push),
        .push_data  (fifo_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        grant = GNT_IDLE;
        if (scan_req) begin
            grant = GNT_RD;
        end else if (!fifo_empty) begin
            grant = GNT_WR;
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 2'd0;
        fifo_pop  = 1'b0;
        case (grant)
            GNT_RD: begin
                ram_addr = pix_addr(scan_x, scan_y);
            end
            GNT_WR: begin
                ram_addr  = fifo_head.addr;
                ram_wdata = fifo_head.shade;
                ram_we    = 1'b1;
                fifo_pop  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock25mhz or negedge resetn) begin
        if (!resetn) begin
            prev_xy_q      <= '1;
            rd_pend_q      <= 1'b0;
            lcd_pend_q     <= 1'b0;
            pix_valid_q    <= 1'b0;
            lcd_q          <= 1'b0;
            shade_q        <= 2'd0;
            wr_drop_q      <= 1'b0;
            scan_overrun_q <= 1'b0;
        end else begin
            prev_xy_q  <= {scan_x, scan_y};
            rd_pend_q  <= scan_req;
            lcd_pend_q <= lcd_on;
            if (rd_pend_q) begin
                pix_valid_q <= 1'b1;
                shade_q     <= ram_rdata;
                lcd_q       <= lcd_pend_q;
            end
            if (wr_valid && wr_ready && !wr_in_range) wr_drop_q <= 1'b1;
            if (scan_req && rd_pend_q) scan_overrun_q <= 1'b1;
        end
    end

    // Palette lookup sits after the shade register so RGB lands two cycles after issue
    always_comb begin
        rgb = 24'h0;
        if (pix_valid_q) begin
            if (!lcd_q) begin
                rgb = PAL0;
            end else begin
                case (shade_q)
                    2'd0:    rgb = PAL0;
                    2'd1:    rgb = PAL1;
                    2'd2:    rgb = PAL2;
                    default: rgb = PAL3;
                endcase
            end
        end
    end

    assign {rgb_r, rgb_g, rgb_b} = rgb;
    assign wr_drop      = wr_drop_q;
    assign scan_overrun = scan_overrun_q;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter; RAM model returns shade ~addr[1:0] one cycle after the address.
module tb_fb_scan_arbiter;

    logic        clock25mhz = 1'b0;
    logic        resetn;
    logic [11:0] scan_x;
    logic [11:0] scan_y;
    logic        lcd_on;
    logic [7:0]  rgb_r;
    logic [7:0]  rgb_g;
    logic [7:0]  rgb_b;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_x;
    logic [7:0]  wr_y;
    logic [1:0]  wr_shade;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [1:0]  ram_wdata;
    logic [1:0]  ram_rdata;
    logic        wr_drop;
    logic        scan_overrun;
    logic [23:0] rgb;

    int errors = 0;
    int checks = 0;

    assign rgb = {rgb_r, rgb_g, rgb_b};

    always #5 clock25mhz = ~clock25mhz;

    always @(posedge clock25mhz) ram_rdata <= ~ram_addr[1:0];

    fb_scan_arbiter dut (
        .clock25mhz   (clock25mhz),
        .resetn       (resetn),
        .scan_x       (scan_x),
        .scan_y       (scan_y),
        .lcd_on       (lcd_on),
        .rgb_r        (rgb_r),
        .rgb_g        (rgb_g),
        .rgb_b        (rgb_b),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_shade     (wr_shade),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .wr_drop      (wr_drop),
        .scan_overrun (scan_overrun)
    );

    task automatic next_cycle();
        @(posedge clock25mhz);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; scan_x = 12'd0; scan_y = 12'd0; lcd_on = 1'b1;
        wr_valid = 1'b0; wr_x = 8'd0; wr_y = 8'd0; wr_shade = 2'd0;
        repeat (2) @(posedge clock25mhz);
        @(negedge clock25mhz);
        checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h want 000000", rgb); end
        checks++; if (ram_we !== 1'b0 || ram_addr !== 15'd0 || ram_wdata !== 2'd0) begin
            errors++; $display("FAIL reset_ram: we=%b addr=%0d wdata=%0d want 0/0/0", ram_we, ram_addr, ram_wdata);
        end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", wr_ready); end
        checks++; if (wr_drop !== 1'b0 || scan_overrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags: drop=%b overrun=%b want 0/0", wr_drop, scan_overrun);
        end
        next_cycle();
        resetn = 1'b1;
        @(negedge clock25mhz);
        checks++; if (ram_we !== 1'b0 || ram_addr !== 15'd0) begin
            errors++; $display("FAIL first_read: we=%b addr=%0d want 0/0", ram_we, ram_addr);
        end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", wr_ready); end
        next_cycle();
        @(negedge clock25mhz);
        checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL first_rgb_c1: got %h want 000000", rgb); end
        next_cycle();
        @(negedge clock25mhz);
        checks++; if (rgb !== 24'h081820) begin errors++; $display("FAIL first_rgb_c2: got %h want 081820", rgb); end
    endtask

    task automatic test_priority();
        logic [11:0] sx [3];
        logic [14:0] rd_exp [3];
        logic [23:0] rgb_exp [3];
        sx = '{12'd5, 12'd6, 12'd5};
        rd_exp = '{15'd325, 15'd326, 15'd325};
        rgb_exp = '{24'h346856, 24'h88C070, 24'h346856};
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            if (k % 3 == 0) begin scan_x = sx[k/3]; scan_y = 12'd2; end
            wr_valid = 1'b1; wr_x = 8'd10; wr_y = 8'd1; wr_shade = 2'd2;
            @(negedge clock25mhz);
            if (k % 3 == 0) begin
                checks++; if (ram_we !== 1'b0 || ram_addr !== rd_exp[k/3]) begin
                    errors++;
                    $display("FAIL prio_read k=%0d: we=%b addr=%0d want 0/%0d", k, ram_we, ram_addr, rd_exp[k/3]);
                end
            end else begin
                checks++; if (ram_we !== 1'b1 || ram_addr !== 15'd170 || ram_wdata !== 2'd2) begin
                    errors++;
                    $display("FAIL prio_write k=%0d: we=%b addr=%0d wdata=%0d want 1/170/2", k, ram_we, ram_addr, ram_wdata);
                end
            end
            if (k % 3 == 2) begin
                checks++; if (rgb !== rgb_exp[k/3]) begin
                    errors++; $display("FAIL prio_rgb k=%0d: got %h want %h", k, rgb, rgb_exp[k/3]);
                end
            end
        end
        wr_valid = 1'b0;
        repeat (5) next_cycle();
        @(negedge clock25mhz);
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL prio_drained: we=%b want 0", ram_we); end
        checks++; if (scan_overrun !== 1'b0) begin errors++; $display("FAIL prio_no_overrun: got %b want 0", scan_overrun); end
    endtask

    task automatic test_drop();
        next_cycle();
        wr_valid = 1'b1; wr_x = 8'd160; wr_y = 8'd0; wr_shade = 2'd1;
        @(negedge clock25mhz);
        checks++; if (wr_ready !== 1'b1 || ram_we !== 1'b0 || wr_drop !== 1'b0) begin
            errors++; $display("FAIL drop_accept: ready=%b we=%b drop=%b want 1/0/0", wr_ready, ram_we, wr_drop);
        end
        next_cycle();
        wr_x = 8'd0; wr_y = 8'd144;
        @(negedge clock25mhz);
        checks++; if (wr_drop !== 1'b1 || ram_we !== 1'b0) begin
            errors++; $display("FAIL drop_x: drop=%b we=%b want 1/0", wr_drop, ram_we);
        end
        next_cycle();
        wr_valid = 1'b0;
        @(negedge clock25mhz);
        checks++; if (wr_drop !== 1'b1 || ram_we !== 1'b0) begin
            errors++; $display("FAIL drop_y: drop=%b we=%b want 1/0", wr_drop, ram_we);
        end
    endtask

    task automatic test_overrun_lcd();
        @(negedge clock25mhz);
        checks++; if (scan_overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b want 0", scan_overrun); end
        next_cycle(); scan_x = 12'd7; scan_y = 12'd0;
        next_cycle(); scan_x = 12'd8;
        next_cycle();
        @(negedge clock25mhz);
        checks++; if (scan_overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", scan_overrun); end
        next_cycle(); scan_x = 12'd9; lcd_on = 1'b0;
        @(negedge clock25mhz);
        checks++; if (rgb !== 24'h081820) begin errors++; $display("FAIL lcd_prev_rgb: got %h want 081820", rgb); end
        next_cycle(); lcd_on = 1'b1;
        @(negedge clock25mhz);
        checks++; if (rgb !== 24'h081820) begin errors++; $display("FAIL lcd_hold_rgb: got %h want 081820", rgb); end
        next_cycle();
        @(negedge clock25mhz);
        checks++; if (rgb !== 24'hE0F8D0) begin errors++; $display("FAIL lcd_off_rgb: got %h want e0f8d0", rgb); end
        checks++; if (scan_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", scan_overrun); end
    endtask

    task automatic test_fifo_full();
        for (int j = 0; j < 9; j++) begin
            next_cycle();
            if (j < 4) begin
                scan_x = 12'(j); scan_y = 12'd3;
                wr_valid = 1'b1; wr_x = 8'(20 + j); wr_y = 8'd4; wr_shade = 2'(j);
            end else if (j == 4) begin
                wr_valid = 1'b1; wr_x = 8'd99; wr_y = 8'd4; wr_shade = 2'd3;
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clock25mhz);
            if (j < 4) begin
                checks++; if (wr_ready !== 1'b1 || ram_we !== 1'b0) begin
                    errors++; $display("FAIL fill j=%0d: ready=%b we=%b want 1/0", j, wr_ready, ram_we);
                end
            end else if (j < 8) begin
                checks++;
                if (ram_we !== 1'b1 || ram_addr !== 15'(656 + j) || ram_wdata !== 2'(j - 4)
                    || wr_ready !== (j != 4)) begin
                    errors++;
                    $display("FAIL drain j=%0d: we=%b addr=%0d wdata=%0d ready=%b want 1/%0d/%0d/%b",
                             j, ram_we, ram_addr, ram_wdata, wr_ready, 656 + j, j - 4, j != 4);
                end
            end else begin
                checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL drain_end: we=%b want 0", ram_we); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            scan_x = 12'(j); scan_y = 12'd6;
            wr_valid = 1'b1; wr_x = 8'(30 + j); wr_y = 8'd5; wr_shade = 2'd1;
            @(negedge clock25mhz);
            checks++; if (wr_ready !== 1'b1 || ram_we !== 1'b0) begin
                errors++; $display("FAIL mid_fill j=%0d: ready=%b we=%b want 1/0", j, wr_ready, ram_we);
            end
        end
        checks++; if (rgb !== 24'h081820) begin errors++; $display("FAIL mid_pre_rgb: got %h want 081820", rgb); end
        next_cycle();
        wr_valid = 1'b0; resetn = 1'b0;
        #1;
        checks++; if (rgb !== 24'h0 || wr_ready !== 1'b0 || ram_we !== 1'b0) begin
            errors++; $display("FAIL mid_reset: rgb=%h ready=%b we=%b want 000000/0/0", rgb, wr_ready, ram_we);
        end
        repeat (2) @(posedge clock25mhz);
        @(negedge clock25mhz);
        checks++; if (scan_overrun !== 1'b0 || wr_drop !== 1'b0) begin
            errors++; $display("FAIL mid_flags: overrun=%b drop=%b want 0/0", scan_overrun, wr_drop);
        end
        next_cycle();
        resetn = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock25mhz);
            checks++; if (ram_we !== 1'b0 || wr_ready !== 1'b1) begin
                errors++; $display("FAIL mid_after j=%0d: we=%b ready=%b want 0/1", j, ram_we, wr_ready);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_drop();
        test_overrun_lcd();
        test_fifo_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
